// File: rtl/digit_entry_bank_pkg.sv
// digit_entry_bank_pkg
// Shared definitions for the digit entry bank: key codes, entry mode
// constants, the decoded key operation type and the key decoder.
package digit_entry_bank_pkg;

    // Key codes. KEY_0..KEY_9 carry their own value in key[3:0].
    localparam logic [4:0] KEY_0   = 5'd0;
    localparam logic [4:0] KEY_1   = 5'd1;
    localparam logic [4:0] KEY_2   = 5'd2;
    localparam logic [4:0] KEY_3   = 5'd3;
    localparam logic [4:0] KEY_4   = 5'd4;
    localparam logic [4:0] KEY_5   = 5'd5;
    localparam logic [4:0] KEY_6   = 5'd6;
    localparam logic [4:0] KEY_7   = 5'd7;
    localparam logic [4:0] KEY_8   = 5'd8;
    localparam logic [4:0] KEY_9   = 5'd9;
    localparam logic [4:0] KEY_BS  = 5'd16;
    localparam logic [4:0] KEY_CLR = 5'd17;

    // Entry modes.
    localparam logic MODE_IDX   = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

    // Decoded key operation.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_DIGIT = 2'd1,
        OP_BS    = 2'd2,
        OP_CLR   = 2'd3
    } key_op_e;

    // Map a raw key code to an operation; unknown codes become OP_NONE.
    function automatic key_op_e decode_key(input logic [4:0] k);
        key_op_e op;
        if (k <= KEY_9) begin
            op = OP_DIGIT;
        end else if (k == KEY_BS) begin
            op = OP_BS;
        end else if (k == KEY_CLR) begin
            op = OP_CLR;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/digit_entry_bank_channel.sv
// digit_channel
// One operand channel: DIGITS BCD digits, an entered-digit count and a
// sticky overflow flag, updated by bulk load/clear or by one decoded key.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load_i          bulk load this channel from load_val_i (count full)
//   clear_i         bulk clear (another channel is being loaded)
//   load_val_i      bulk load value, digit i at [i*DW +: DW]
//   key_en_i        a key is addressed to this channel this cycle
//   op_i            decoded key operation
//   mode_i          MODE_IDX / MODE_SHIFT sampled with the key
//   index_i         target digit for indexed mode
//   digit_i         digit value of the key (key[3:0])
//   digits_o        registered digits
//   count_o         registered entered-digit count
//   ovf_o           registered sticky overflow flag
//   accept_o        combinational: the key produced an accepted event
module digit_channel
    import digit_entry_bank_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DW     = 4,
    parameter int IW     = 2,
    parameter int CW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [DIGITS*DW-1:0] load_val_i,
    input  logic                 key_en_i,
    input  key_op_e              op_i,
    input  logic                 mode_i,
    input  logic [IW-1:0]        index_i,
    input  logic [3:0]           digit_i,
    output logic [DIGITS*DW-1:0] digits_o,
    output logic [CW-1:0]        count_o,
    output logic                 ovf_o,
    output logic                 accept_o
);

    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW:0]   IDX_LIM  = (IW+1)'(DIGITS);

    logic [DIGITS-1:0][DW-1:0] dig_q, dig_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      accept_s;
    logic                      idx_ok_s;
    logic [CW-1:0]             idx_cnt_s;
    logic [DW-1:0]             key_dig_s;

    // Index range check and the count implied by writing that index.
    always_comb begin
        idx_ok_s  = ({1'b0, index_i} < IDX_LIM);
        idx_cnt_s = CW'(index_i) + CNT_ONE;
        key_dig_s = DW'(digit_i);
    end

    // Next-state for digits, count and overflow; load/clear beat any key.
    always_comb begin
        dig_d    = dig_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        accept_s = 1'b0;
        if (load_i) begin
            dig_d = load_val_i;
            cnt_d = CNT_FULL;
            ovf_d = 1'b0;
        end else if (clear_i) begin
            dig_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (key_en_i) begin
            case (op_i)
                OP_CLR: begin
                    dig_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    accept_s = 1'b1;
                end
                OP_DIGIT: begin
                    if (mode_i == MODE_SHIFT) begin
                        // A full channel still reports the key, via ovf.
                        if (cnt_q < CNT_FULL) begin
                            for (int i = 1; i < DIGITS; i++) begin
                                dig_d[i] = dig_q[i-1];
                            end
                            dig_d[0] = key_dig_s;
                            cnt_d    = cnt_q + CNT_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        accept_s = 1'b1;
                    end else if (idx_ok_s) begin
                        dig_d[index_i] = key_dig_s;
                        if (idx_cnt_s > cnt_q) begin
                            cnt_d = idx_cnt_s;
                        end else begin
                            cnt_d = cnt_q;
                        end
                        accept_s = 1'b1;
                    end else begin
                        accept_s = 1'b0;
                    end
                end
                OP_BS: begin
                    if (mode_i == MODE_SHIFT) begin
                        if (cnt_q != '0) begin
                            for (int i = 0; i < DIGITS - 1; i++) begin
                                dig_d[i] = dig_q[i+1];
                            end
                            dig_d[DIGITS-1] = '0;
                            cnt_d    = cnt_q - CNT_ONE;
                            accept_s = 1'b1;
                        end else begin
                            accept_s = 1'b0;
                        end
                    end else if (idx_ok_s) begin
                        dig_d[index_i] = '0;
                        accept_s = 1'b1;
                    end else begin
                        accept_s = 1'b0;
                    end
                end
                default: begin
                    accept_s = 1'b0;
                end
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            dig_q <= dig_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign digits_o = dig_q;
    assign count_o  = cnt_q;
    assign ovf_o    = ovf_q;
    assign accept_o = accept_s;

endmodule

// File: rtl/digit_entry_bank.sv
// digit_entry_bank
// Bank of CHANNELS BCD operand registers filled from a keypad, either
// calculator-style (shift) or by digit index, with bulk load via set.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   key_valid     one-cycle key qualifier
//   key           key code (digits, KEY_BS, KEY_CLR)
//   ch_sel        channel addressed by the key
//   index         digit addressed in indexed mode
//   mode          MODE_IDX / MODE_SHIFT
//   set, set_ch, set_val   bulk load of one channel, others cleared
//   digits_o      all channel digits, channel c at [c*DIGITS*DW +: DIGITS*DW]
//   count_o       entered-digit counts, channel c at [c*CW +: CW]
//   ovf_o         sticky overflow flags
//   upd_o         one-cycle pulse after any accepted event
module digit_entry_bank
    import digit_entry_bank_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DIGITS   = 4,
    parameter int DW       = 4,
    localparam int CSW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW      = $clog2(DIGITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [4:0]                    key,
    input  logic [CSW-1:0]                ch_sel,
    input  logic [IW-1:0]                 index,
    input  logic                          mode,
    input  logic                          set,
    input  logic [CSW-1:0]                set_ch,
    input  logic [DIGITS*DW-1:0]          set_val,
    output logic [CHANNELS*DIGITS*DW-1:0] digits_o,
    output logic [CHANNELS*CW-1:0]        count_o,
    output logic [CHANNELS-1:0]           ovf_o,
    output logic                          upd_o
);

    localparam logic [CSW:0] CH_LIM = (CSW+1)'(CHANNELS);

    key_op_e               op_s;
    logic                  key_ok_s;
    logic [CHANNELS-1:0]   accept_s;
    logic                  upd_q, upd_d;

    // Decode the key once; set suppresses any key in the same cycle.
    always_comb begin
        op_s     = decode_key(key);
        key_ok_s = key_valid & ~set & ({1'b0, ch_sel} < CH_LIM) & (op_s != OP_NONE);
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            localparam logic [CSW-1:0] C_ID = CSW'(c);
            logic load_s, clear_s, key_en_s;

            // Route set and key requests to this channel.
            always_comb begin
                load_s   = set & (set_ch == C_ID);
                clear_s  = set & (set_ch != C_ID);
                key_en_s = key_ok_s & (ch_sel == C_ID);
            end

            digit_channel #(
                .DIGITS (DIGITS),
                .DW     (DW),
                .IW     (IW),
                .CW     (CW)
            ) u_channel (
                .clk        (clk),
                .rst        (rst),
                .load_i     (load_s),
                .clear_i    (clear_s),
                .load_val_i (set_val),
                .key_en_i   (key_en_s),
                .op_i       (op_s),
                .mode_i     (mode),
                .index_i    (index),
                .digit_i    (key[3:0]),
                .digits_o   (digits_o[c*DIGITS*DW +: DIGITS*DW]),
                .count_o    (count_o[c*CW +: CW]),
                .ovf_o      (ovf_o[c]),
                .accept_o   (accept_s[c])
            );
        end
    endgenerate

    // Any set or accepted key produces one update pulse.
    always_comb begin
        upd_d = set | (|accept_s);
    end

    // Update pulse register, aligned with the channel state it reports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_q <= 1'b0;
        end else begin
            upd_q <= upd_d;
        end
    end

    assign upd_o = upd_q;

endmodule

// File: tb/tb_digit_entry_bank.sv
// tb_digit_entry_bank
// Directed-vector bench for digit_entry_bank with default parameters
// (2 channels, 4 digits of 4 bits). Expected values are hand computed.
module tb_digit_entry_bank;
    import digit_entry_bank_pkg::*;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key;
    logic [0:0]  ch_sel;
    logic [1:0]  index;
    logic        mode;
    logic        set;
    logic [0:0]  set_ch;
    logic [15:0] set_val;
    logic [31:0] digits_o;
    logic [5:0]  count_o;
    logic [1:0]  ovf_o;
    logic        upd_o;

    int n_checks = 0;
    int n_errors = 0;

    digit_entry_bank dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key       (key),
        .ch_sel    (ch_sel),
        .index     (index),
        .mode      (mode),
        .set       (set),
        .set_ch    (set_ch),
        .set_val   (set_val),
        .digits_o  (digits_o),
        .count_o   (count_o),
        .ovf_o     (ovf_o),
        .upd_o     (upd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one key for one cycle; return #1 after the accepting edge.
    task automatic press(input logic [0:0] ch, input logic md, input logic [1:0] idx,
                         input logic [4:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        ch_sel    = ch;
        mode      = md;
        index     = idx;
        key       = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key = 5'd0; ch_sel = 1'b0; index = 2'd0;
        mode = MODE_SHIFT; set = 1'b0; set_ch = 1'b0; set_val = 16'h0000;
        #12;
        chk("rst_digits", 64'(digits_o), 64'h0);
        chk("rst_count",  64'(count_o),  64'h0);
        chk("rst_ovf",    64'(ovf_o),    64'h0);
        chk("rst_upd",    64'(upd_o),    64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Shift entry on channel 0.
        press(1'b0, MODE_SHIFT, 2'd0, KEY_1);
        chk("sh1_upd", 64'(upd_o), 64'h1);
        press(1'b0, MODE_SHIFT, 2'd0, KEY_2);
        chk("sh2_upd", 64'(upd_o), 64'h1);
        press(1'b0, MODE_SHIFT, 2'd0, KEY_3);
        chk("sh3_upd",    64'(upd_o),          64'h1);
        chk("sh3_digits", 64'(digits_o[15:0]), 64'h0123);
        chk("sh3_count",  64'(count_o[2:0]),   64'h3);
        idle();
        chk("sh_idle_upd", 64'(upd_o), 64'h0);

        // Shift entry on channel 1 with overflow, then clear.
        press(1'b1, MODE_SHIFT, 2'd0, KEY_9);
        press(1'b1, MODE_SHIFT, 2'd0, KEY_8);
        press(1'b1, MODE_SHIFT, 2'd0, KEY_7);
        press(1'b1, MODE_SHIFT, 2'd0, KEY_6);
        chk("ch1_full_ovf", 64'(ovf_o[1]), 64'h0);
        press(1'b1, MODE_SHIFT, 2'd0, KEY_5);
        chk("ch1_ovf_upd",    64'(upd_o),           64'h1);
        chk("ch1_ovf_digits", 64'(digits_o[31:16]), 64'h9876);
        chk("ch1_ovf_count",  64'(count_o[5:3]),    64'h4);
        chk("ch1_ovf_flag",   64'(ovf_o[1]),        64'h1);
        chk("ch0_hold",       64'(digits_o[15:0]),  64'h0123);
        press(1'b1, MODE_SHIFT, 2'd0, KEY_CLR);
        chk("ch1_clr_digits", 64'(digits_o[31:16]), 64'h0);
        chk("ch1_clr_ovf",    64'(ovf_o[1]),        64'h0);
        chk("ch1_clr_count",  64'(count_o[5:3]),    64'h0);

        // Shift backspace on channel 0, down past empty.
        press(1'b0, MODE_SHIFT, 2'd0, KEY_BS);
        chk("bs1_digits", 64'(digits_o[15:0]), 64'h0012);
        chk("bs1_count",  64'(count_o[2:0]),   64'h2);
        press(1'b0, MODE_SHIFT, 2'd0, KEY_BS);
        press(1'b0, MODE_SHIFT, 2'd0, KEY_BS);
        chk("bs3_digits", 64'(digits_o[15:0]), 64'h0000);
        chk("bs3_count",  64'(count_o[2:0]),   64'h0);
        chk("bs3_upd",    64'(upd_o),          64'h1);
        press(1'b0, MODE_SHIFT, 2'd0, KEY_BS);
        chk("bs_empty_upd",   64'(upd_o),        64'h0);
        chk("bs_empty_count", 64'(count_o[2:0]), 64'h0);

        // Indexed mode on channel 0.
        press(1'b0, MODE_IDX, 2'd2, KEY_7);
        chk("idx_digits", 64'(digits_o[15:0]), 64'h0700);
        chk("idx_count",  64'(count_o[2:0]),   64'h3);
        press(1'b0, MODE_IDX, 2'd2, KEY_BS);
        chk("idx_bs_digits", 64'(digits_o[15:0]), 64'h0000);
        chk("idx_bs_count",  64'(count_o[2:0]),   64'h3);
        chk("idx_bs_upd",    64'(upd_o),          64'h1);
        press(1'b0, MODE_IDX, 2'd0, KEY_4);
        chk("idx_low_digits", 64'(digits_o[15:0]), 64'h0004);
        chk("idx_low_count",  64'(count_o[2:0]),   64'h3);

        // Unknown key code is ignored.
        press(1'b0, MODE_SHIFT, 2'd0, 5'd12);
        chk("badkey_upd",    64'(upd_o),          64'h0);
        chk("badkey_digits", 64'(digits_o[15:0]), 64'h0004);

        // Set wins over a simultaneous key.
        @(negedge clk);
        set = 1'b1; set_ch = 1'b1; set_val = 16'h4321;
        key_valid = 1'b1; ch_sel = 1'b0; mode = MODE_SHIFT; key = KEY_5;
        @(posedge clk);
        #1;
        set = 1'b0; key_valid = 1'b0;
        chk("set_digits", 64'(digits_o), 64'h4321_0000);
        chk("set_count",  64'(count_o),  64'h20);
        chk("set_upd",    64'(upd_o),    64'h1);

        // Back-to-back keys with a mode change between them.
        press(1'b0, MODE_SHIFT, 2'd0, KEY_1);
        chk("b2b1_digits", 64'(digits_o[15:0]), 64'h0001);
        press(1'b0, MODE_IDX, 2'd3, KEY_9);
        chk("b2b2_digits", 64'(digits_o[15:0]), 64'h9001);
        chk("b2b2_count",  64'(count_o[2:0]),   64'h4);
        press(1'b0, MODE_SHIFT, 2'd0, KEY_2);
        chk("b2b3_ovf", 64'(ovf_o), 64'h1);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_digits", 64'(digits_o), 64'h0);
        chk("arst_count",  64'(count_o),  64'h0);
        chk("arst_ovf",    64'(ovf_o),    64'h0);
        chk("arst_upd",    64'(upd_o),    64'h0);
        @(negedge clk);
        rst = 1'b1;
        press(1'b0, MODE_SHIFT, 2'd0, KEY_8);
        chk("post_rst_digits", 64'(digits_o[15:0]), 64'h0008);
        chk("post_rst_count",  64'(count_o[2:0]),   64'h1);
        chk("post_rst_upd",    64'(upd_o),          64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
